// File: rtl/pipeline_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
package pipeline_pkg;

  localparam int MULDIV_XLEN    = 32;
  localparam int MULDIV_DIV_LAT = MULDIV_XLEN + 1;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_div_iter.sv
// Iterative restoring radix-2 unsigned divider, one quotient bit per cycle.
// quotient/remainder show the values after the current step, so they are
// final in the cycle where last is high.
module muldiv_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            busy,
  output logic            last
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] rem_q, quo_q, div_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_d, quo_d;

  // One trial subtraction of the shifted partial remainder.
  always_comb begin
    trial = {rem_q, quo_q[XLEN-1]} - {1'b0, div_q};
    rem_d = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
    quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
  end

  // Iteration registers; a load restarts the divider at any time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      div_q  <= divisor;
      cnt_q  <= CW'(XLEN - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) busy_q <= 1'b0;
    end
  end

  assign quotient  = quo_d;
  assign remainder = rem_d;
  assign busy      = busy_q;
  assign last      = busy_q && (cnt_q == '0);

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit for the EX stage. Holds the pipeline with
// stall while an operation runs and pulses done for one cycle with the
// registered result.
//
// state | meaning
// IDLE  | waiting for start; accepts and latches operands
// MUL   | one-cycle 33x33 signed multiply, result registered
// DIV   | iterating the unsigned divider on operand magnitudes
// DONE  | result valid (done=1), start ignored, back to IDLE
module ex_muldiv_unit
  import pipeline_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [4:0]      rd_q, rd_d;
  logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  logic            accept, in_div, in_signed, in_rem, b_zero, ovf, div_load;
  logic [XLEN-1:0] abs_a, abs_b, div_quo, div_rem, div_res;
  logic            div_busy, div_last;
  logic signed [XLEN:0]     mul_a, mul_b;
  logic signed [2*XLEN+1:0] prod;
  logic [XLEN-1:0] mul_res;
  logic            unused_ok;

  // Decode of the incoming instruction and divide special cases.
  always_comb begin
    accept    = (state_q == ST_IDLE) && start && !flush;
    in_div    = funct3[2];
    in_signed = !funct3[0];
    in_rem    = funct3[1];
    b_zero    = (src_b == '0);
    ovf       = in_signed && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    abs_a     = (in_signed && src_a[XLEN-1]) ? -src_a : src_a;
    abs_b     = (in_signed && src_b[XLEN-1]) ? -src_b : src_b;
    div_load  = accept && in_div && !b_zero && !ovf;
  end

  muldiv_div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .busy      (div_busy),
    .last      (div_last)
  );

  // Multiplier on latched operands, plus sign fix-up of divider outputs.
  always_comb begin
    mul_a   = {(op_q == OP_MULH || op_q == OP_MULHSU) && a_q[XLEN-1], a_q};
    mul_b   = {(op_q == OP_MULH) && b_q[XLEN-1], b_q};
    prod    = mul_a * mul_b;
    mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    if (op_q == OP_REM || op_q == OP_REMU)
      div_res = r_neg_q ? -div_rem : div_rem;
    else
      div_res = q_neg_q ? -div_quo : div_quo;
  end

  assign unused_ok = ^{prod[2*XLEN+1:2*XLEN], div_busy};

  // Next-state and result selection.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rd_d     = rd_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = muldiv_op_e'(funct3);
          a_d     = src_a;
          b_d     = src_b;
          rd_d    = rd_in;
          q_neg_d = in_signed && (src_a[XLEN-1] ^ src_b[XLEN-1]);
          r_neg_d = in_signed && src_a[XLEN-1];
          if (!in_div) begin
            state_d = ST_MUL;
          end else if (b_zero) begin
            result_d = in_rem ? src_a : '1;
            state_d  = ST_DONE;
          end else if (ovf) begin
            result_d = in_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d  = ST_DONE;
          end else begin
            state_d = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          result_d = mul_res;
          state_d  = ST_DONE;
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (div_last) begin
          result_d = div_res;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  assign stall  = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
  assign done   = (state_q == ST_DONE) && !flush;
  assign result = result_q;
  assign rd_out = rd_q;

endmodule
